saradc_scan_ctrl: RTL and testbench

SARADC_SCAN_CTRL -- requirements
Module: saradc_scan_ctrl

---
 rtl/saradc_scan_ctrl_pkg.sv | 21 ++
 rtl/saradc_scan_ctrl_if.sv | 32 +++
 rtl/saradc_scan_ctrl_rr_arb.sv | 32 +++
 rtl/saradc_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_saradc_scan_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/saradc_scan_ctrl_pkg.sv
// Shared types and default sizing for the SAR ADC scan controller.
package saradc_ctrl_pkg;

  localparam int DEF_NBITS    = 5;
  localparam int DEF_NREQ     = 4;
  localparam int DEF_OSR_LOG2 = 2;
  localparam int DEF_TMO_CYC  = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Index width that stays legal for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/saradc_scan_ctrl_if.sv
// Requester and SAR-logic signals of the scan controller, bundled in one interface.
interface saradc_scan_ctrl_if
  import saradc_ctrl_pkg::*;
#(
  parameter int NBITS    = DEF_NBITS,
  parameter int NREQ     = DEF_NREQ,
  parameter int OSR_LOG2 = DEF_OSR_LOG2
);
  localparam int ID_W = id_width(NREQ);

  logic [NREQ-1:0]           req;
  logic [NREQ-1:0]           ack;
  logic [NBITS+OSR_LOG2-1:0] dout;
  logic [ID_W-1:0]           dout_id;
  logic                      err;
  logic                      busy;
  logic                      adc_go;
  logic                      adc_valid;
  logic [NBITS-1:0]          adc_result;

  // The controller is the slave of the requesters and drives the SAR logic.
  modport slave (
    input  req, adc_valid, adc_result,
    output ack, dout, dout_id, err, busy, adc_go
  );

  modport master (
    output req, adc_valid, adc_result,
    input  ack, dout, dout_id, err, busy, adc_go
  );

endinterface

// File: rtl/saradc_scan_ctrl_rr_arb.sv
// Round-robin pick: first asserted request at or above ptr, wrapping past NREQ-1.
module saradc_rr_arb
  import saradc_ctrl_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] winner,
  output logic            valid
);
  localparam int IW = ID_W + 1;

  logic [IW-1:0] idx;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + IW'(i);
      if (idx >= IW'(NREQ)) idx = idx - IW'(NREQ);
      if (!valid && req[idx[ID_W-1:0]]) begin
        winner = idx[ID_W-1:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/saradc_scan_ctrl.sv
// Round-robin scan controller: grants one requester, oversamples 2^OSR_LOG2 SAR
// conversions into a sum, and acknowledges it, with a per-conversion watchdog.
module saradc_scan_ctrl
  import saradc_ctrl_pkg::*;
#(
  parameter int NBITS    = DEF_NBITS,
  parameter int NREQ     = DEF_NREQ,
  parameter int OSR_LOG2 = DEF_OSR_LOG2,
  parameter int TMO_CYC  = DEF_TMO_CYC
) (
  input logic              clk,
  input logic              rst,
  saradc_scan_ctrl_if.slave bus
);
  localparam int ID_W  = id_width(NREQ);
  localparam int ACC_W = NBITS + OSR_LOG2;
  localparam int CNT_W = OSR_LOG2 + 1;
  localparam int WD_W  = $clog2(TMO_CYC + 1);

  localparam logic [CNT_W-1:0] BATCH    = CNT_W'(2 ** OSR_LOG2);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TMO_CYC);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NREQ - 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              timeout;

  logic [ID_W-1:0]   arb_winner;
  logic              arb_valid;

  logic [NREQ-1:0]   ack_q;
  logic [ACC_W-1:0]  dout_q;
  logic [ID_W-1:0]   dout_id_q;
  logic              err_q, busy_q, adc_go_q;

  saradc_rr_arb #(.NREQ(NREQ)) u_arb (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    wdog_d  = wdog_q;
    timeout = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_winner;
          acc_d   = '0;
          cnt_d   = '0;
          wdog_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        // A VALID still high here belongs to the previous conversion; hold GO until it drops.
        wdog_d = wdog_q + 1'b1;
        if (wdog_d == WD_LIMIT) begin
          timeout = 1'b1;
          state_d = ST_DONE;
        end else if (!bus.adc_valid) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (bus.adc_valid) begin
          acc_d = acc_q + ACC_W'(bus.adc_result);
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == BATCH) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_START;
            wdog_d  = '0;
          end
        end else if (wdog_d == WD_LIMIT) begin
          timeout = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one tracks the state it belongs to.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      wdog_q    <= '0;
      ack_q     <= '0;
      dout_q    <= '0;
      dout_id_q <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      adc_go_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
      busy_q   <= (state_d != ST_IDLE);
      adc_go_q <= (state_d == ST_START);
      err_q    <= timeout;
      ack_q    <= (state_d == ST_DONE) ? (NREQ'(1) << grant_d) : '0;
      if (state_d == ST_DONE) begin
        dout_q    <= timeout ? '0 : acc_d;
        dout_id_q <= grant_d;
      end
    end
  end

  assign bus.ack     = ack_q;
  assign bus.dout    = dout_q;
  assign bus.dout_id = dout_id_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
  assign bus.adc_go  = adc_go_q;

endmodule

// File: tb/tb_saradc_scan_ctrl.sv
// Bench for saradc_scan_ctrl: SAR logic model, directed vectors, corner sequences, random scoreboard.
module tb_saradc_scan_ctrl;
  import saradc_ctrl_pkg::*;

  localparam int NBITS    = 5;
  localparam int NREQ     = 4;
  localparam int OSR_LOG2 = 2;
  localparam int TMO_CYC  = 255;
  localparam int BATCH    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  saradc_scan_ctrl_if #(.NBITS(NBITS), .NREQ(NREQ), .OSR_LOG2(OSR_LOG2)) bus ();

  saradc_scan_ctrl #(
    .NBITS(NBITS), .NREQ(NREQ), .OSR_LOG2(OSR_LOG2), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // SAR logic model: GO starts a conversion and drops VALID (optionally after a few stale
  // cycles); VALID rises with a result lat cycles after GO falls and is held until next GO.
  bit   never_valid = 1'b0;
  int   stale_hold  = 0;
  int   lat_min     = 1;
  int   lat_max     = 3;
  int   res_q[$];
  int   conv_log[$];
  bit   pending     = 1'b0;
  int   countdown   = 0;
  int   hold_left   = 0;
  int   go_rises    = 0;
  int   go_run      = 0;
  int   go_run_max  = 0;
  logic go_prev     = 1'b0;

  always @(negedge clk) begin
    int v;
    if (rst) begin
      bus.adc_valid  = 1'b0;
      bus.adc_result = '0;
      pending        = 1'b0;
      go_prev        = 1'b0;
      go_run         = 0;
    end else begin
      if (bus.adc_go && !go_prev) go_rises++;
      if (bus.adc_go) begin
        go_run++;
        if (go_run > go_run_max) go_run_max = go_run;
      end else begin
        go_run = 0;
      end
      go_prev = bus.adc_go;
      if (never_valid) begin
        bus.adc_valid = 1'b0;
        pending       = 1'b0;
      end else if (bus.adc_go) begin
        if (bus.adc_valid && hold_left > 0) begin
          hold_left--;
        end else begin
          bus.adc_valid = 1'b0;
          pending       = 1'b1;
          countdown     = $urandom_range(lat_max, lat_min);
        end
      end else if (pending) begin
        if (countdown > 1) begin
          countdown--;
        end else begin
          v = (res_q.size() > 0) ? res_q.pop_front() : int'($urandom_range(31, 0));
          bus.adc_result = NBITS'(v);
          bus.adc_valid  = 1'b1;
          pending        = 1'b0;
          hold_left      = stale_hold;
          conv_log.push_back(v);
        end
      end
    end
  end

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  function automatic int oh2idx(input logic [NREQ-1:0] a);
    for (int i = 0; i < NREQ; i++)
      if (a[i]) return i;
    return -1;
  endfunction

  function automatic int log_sum();
    int s = 0;
    foreach (conv_log[i]) s += conv_log[i];
    return s;
  endfunction

  // Waits on negedges for a nonzero ACK; an expired budget counts as a failure.
  task automatic wait_ack(input string name, input int budget,
                          output logic [NREQ-1:0] a, output int busy_cyc);
    a = '0;
    busy_cyc = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        a = bus.ack;
        return;
      end
      if (bus.busy) busy_cyc++;
    end
    total++;
    bad++;
    $display("FAIL %s: no ACK within %0d cycles", name, budget);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    int r0, r1, r2, r3;
    int exp_dout;
    int exp_id;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [NREQ-1:0] a;
    logic [NREQ-1:0] req_v;
    logic [NREQ-1:0] seen;
    int bc, gap, exp_id, ref_ptr, act_id, max_wait;
    int waits[NREQ];

    vecs[0] = '{4'b0001, 3, 5, 7, 9, 24, 0};
    vecs[1] = '{4'b0100, 31, 31, 31, 31, 124, 2};
    vecs[2] = '{4'b1000, 0, 0, 0, 0, 0, 3};
    vecs[3] = '{4'b0010, 1, 30, 2, 29, 62, 1};

    bus.req = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", bus.ack, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_go", bus.adc_go, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_id", bus.dout_id, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b0;

    // Directed vectors: single requester, known conversion results.
    for (int k = 0; k < 4; k++) begin
      conv_log.delete();
      res_q = '{vecs[k].r0, vecs[k].r1, vecs[k].r2, vecs[k].r3};
      go_rises = 0;
      bus.req = vecs[k].req;
      wait_ack($sformatf("vec%0d", k), 400, a, bc);
      bus.req = '0;
      check($sformatf("vec%0d_ack", k), a, 1 << vecs[k].exp_id);
      check($sformatf("vec%0d_dout", k), bus.dout, vecs[k].exp_dout);
      check($sformatf("vec%0d_id", k), bus.dout_id, vecs[k].exp_id);
      check($sformatf("vec%0d_err", k), bus.err, 0);
      check($sformatf("vec%0d_go", k), go_rises, BATCH);
      @(negedge clk);
      check($sformatf("vec%0d_ack_len", k), bus.ack, 0);
      check($sformatf("vec%0d_idle", k), bus.busy, 0);
      check($sformatf("vec%0d_dout_hold", k), bus.dout, vecs[k].exp_dout);
    end

    // Contention: all four held, pointer walks 0..3 and wraps back to 0.
    pulse_reset();
    bus.req = 4'b1111;
    conv_log.delete();
    for (int k = 0; k < 5; k++) begin
      wait_ack($sformatf("rr%0d", k), 400, a, bc);
      check($sformatf("rr%0d_id", k), oh2idx(a), k % NREQ);
      check($sformatf("rr%0d_dout", k), bus.dout, log_sum());
      conv_log.delete();
      if (k == 4) begin
        bus.req = '0;
      end else begin
        gap = 0;
        for (int c = 0; c < 20 && !bus.adc_go; c++) begin
          @(negedge clk);
          gap++;
        end
        check($sformatf("rr%0d_gap", k), gap, 2);
      end
    end

    // Watchdog: SAR logic never answers; pointer is 1 after the wrap above.
    never_valid = 1'b1;
    bus.req = 4'b0010;
    wait_ack("wdog", 600, a, bc);
    bus.req = '0;
    check("wdog_cycles", bc, TMO_CYC);
    check("wdog_ack", a, 4'b0010);
    check("wdog_err", bus.err, 1);
    check("wdog_dout", bus.dout, 0);
    check("wdog_id", bus.dout_id, 1);
    check("wdog_go", bus.adc_go, 0);
    @(negedge clk);
    check("wdog_err_len", bus.err, 0);
    check("wdog_idle", bus.busy, 0);
    never_valid = 1'b0;

    // Reset mid-batch with a nonzero pointer: batch is dropped and the pointer returns to 0.
    conv_log.delete();
    bus.req = 4'b0100;
    for (int c = 0; c < 200 && conv_log.size() < 2; c++) @(negedge clk);
    check("mid_convs", conv_log.size(), 2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_busy", bus.busy, 0);
    check("mid_go", bus.adc_go, 0);
    check("mid_ack", bus.ack, 0);
    rst = 1'b0;
    bus.req = '0;
    seen = '0;
    repeat (6) begin
      @(negedge clk);
      seen |= bus.ack;
    end
    check("mid_no_ack", seen, 0);
    conv_log.delete();
    bus.req = 4'b1111;
    wait_ack("post_rst", 400, a, bc);
    bus.req = '0;
    check("post_rst_ack", a, 4'b0001);
    check("post_rst_dout", bus.dout, log_sum());

    // Stale VALID held two extra cycles into every START; pointer is 1 here.
    stale_hold = 2;
    conv_log.delete();
    res_q = '{10, 20, 1, 4};
    go_rises = 0;
    go_run_max = 0;
    bus.req = 4'b1000;
    wait_ack("stale", 400, a, bc);
    bus.req = '0;
    check("stale_ack", a, 4'b1000);
    check("stale_dout", bus.dout, 35);
    check("stale_go", go_rises, BATCH);
    check("stale_go_run", go_run_max, 3);
    stale_hold = 0;

    // Random requests, latencies and results against a round-robin scoreboard.
    pulse_reset();
    ref_ptr = 0;
    req_v = '0;
    max_wait = 0;
    foreach (waits[j]) waits[j] = 0;
    conv_log.delete();
    for (int b = 0; b < 60; b++) begin
      if (req_v == '0) req_v = NREQ'($urandom_range(15, 1));
      lat_max = $urandom_range(4, 1);
      stale_hold = $urandom_range(2, 0);
      bus.req = req_v;
      exp_id = rr_pick(req_v, ref_ptr);
      wait_ack($sformatf("rnd%0d", b), 400, a, bc);
      act_id = oh2idx(a);
      check($sformatf("rnd%0d_ack", b), a, 1 << exp_id);
      check($sformatf("rnd%0d_dout", b), bus.dout, log_sum());
      check($sformatf("rnd%0d_id", b), bus.dout_id, exp_id);
      check($sformatf("rnd%0d_err", b), bus.err, 0);
      conv_log.delete();
      for (int j = 0; j < NREQ; j++) begin
        if (j == act_id) waits[j] = 0;
        else if (req_v[j]) waits[j]++;
        if (waits[j] > max_wait) max_wait = waits[j];
      end
      ref_ptr = (exp_id + 1) % NREQ;
      req_v[exp_id] = 1'b0;
      if ($urandom_range(1, 0) == 1) req_v |= NREQ'($urandom_range(15, 0));
      bus.req = req_v;
    end
    bus.req = '0;
    check("rnd_starve", max_wait <= NREQ - 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
